// File: rtl/uart_pkg.sv
// Shared types and default constants for the UART receive path.
package uart_pkg;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_OVERSAMPLE = 16;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_frame.sv
// UART receive frame controller: start detect, mid-bit sampling,
// stop check and a single-entry valid/ready output buffer.
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = UART_DATA_BITS,
    parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sample_tick,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 framing_error,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int IDX_W = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0] MID_CNT  = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] END_CNT  = CNT_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    rx_state_e state_q;

    logic [CNT_W-1:0]     cnt_q;
    logic [CNT_W-1:0]     cnt_d;
    logic [IDX_W-1:0]     idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] shift_d;
    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q;
    logic                 ferr_q;
    logic                 ovr_q;

    logic rx_s;
    logic cnt_mid;
    logic cnt_end;
    logic frame_end;
    logic frame_good;
    logic blocked;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (rx_in),
        .q_o   (rx_s)
    );

    always_comb begin
        cnt_d      = cnt_q + CNT_W'(1);
        shift_d    = {rx_s, shift_q[DATA_BITS-1:1]};
        cnt_mid    = (cnt_q == MID_CNT);
        cnt_end    = (cnt_q == END_CNT);
        frame_end  = sample_tick && (state_q == STOP) && cnt_end;
        frame_good = frame_end && rx_s;
        // A full buffer only blocks a new byte if nobody drains it now.
        blocked    = valid_q && !data_ready;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            ferr_q <= frame_end && !rx_s;
            ovr_q  <= frame_good && blocked;

            if (frame_good && !blocked) begin
                data_q  <= shift_q;
                valid_q <= 1'b1;
            end else if (data_ready) begin
                valid_q <= 1'b0;
            end

            if (sample_tick) begin
                unique case (state_q)
                    IDLE: begin
                        if (!rx_s) begin
                            state_q <= START;
                            cnt_q   <= '0;
                        end
                    end
                    START: begin
                        if (cnt_mid) begin
                            cnt_q   <= '0;
                            idx_q   <= '0;
                            state_q <= rx_s ? IDLE : DATA;
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end
                    DATA: begin
                        cnt_q <= cnt_d;
                        if (cnt_end) begin
                            shift_q <= shift_d;
                            idx_q   <= idx_q + IDX_W'(1);
                            if (idx_q == LAST_IDX) begin
                                state_q <= STOP;
                            end
                        end
                    end
                    STOP: begin
                        cnt_q <= cnt_d;
                        if (cnt_end) begin
                            state_q <= IDLE;
                        end
                    end
                endcase
            end
        end
    end

    assign data_out      = data_q;
    assign data_valid    = valid_q;
    assign framing_error = ferr_q;
    assign overrun       = ovr_q;
    assign busy          = (state_q != IDLE);

endmodule
